// File: rtl/uart_tx_buf_pkg.sv
// Shared types and sizing for the buffered UART transmitter.
package uart_tx_buf_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int COUNT_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  // Pointers are exactly log2(depth) wide, so the natural wrap gives 3 -> 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/uart_tx_buf_if.sv
// Write-side handshake plus serial line of the buffered UART transmitter.
interface uart_tx_buf_if;
  import uart_tx_buf_pkg::*;

  logic [DATA_W-1:0] data;
  logic              start;
  logic              ready;
  logic              busy;
  logic              tx;

  modport master (
    output data,
    output start,
    input  ready,
    input  busy,
    input  tx
  );

  modport slave (
    input  data,
    input  start,
    output ready,
    output busy,
    output tx
  );

endinterface

// File: rtl/baudgen.vh
// Baud divisors for a 12 MHz system clock: clock cycles per serial bit.
`ifndef BAUDGEN_VH
`define BAUDGEN_VH

`define B115200 104
`define B57600  208
`define B38400  313
`define B19200  625
`define B9600   1250
`define B4800   2500
`define B2400   5000
`define B1200   10000
`define B600    20000
`define B300    40000

`endif

// File: rtl/uart_tx_buf_baudgen_tx.sv
// Bit-period timer: one-cycle tick every BAUDRATE cycles, restarted by clr.
`include "baudgen.vh"

module baudgen_tx #(
  parameter int BAUDRATE = `B115200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUDRATE - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = (cnt_reg == LAST) && !clr;

  // Wrapping on the tick is the reload, so consecutive bits share one time base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || (cnt_reg == LAST)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// UART transmitter with a 4-entry character FIFO in front of an 8N1 serialiser.
`include "baudgen.vh"

module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int BAUDRATE = `B115200
) (
  input  logic         clk,
  input  logic         rst,
  uart_tx_buf_if.slave bus
);

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [COUNT_W-1:0] count_reg;

  tx_state_t          state_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic [2:0]         bit_idx_reg;
  logic               tx_reg;

  logic ready;
  logic wr_en;
  logic pop;
  logic tick;
  logic baud_clr;

  assign ready    = (count_reg != COUNT_W'(FIFO_DEPTH));
  assign wr_en    = bus.start && ready;
  assign pop      = (count_reg != '0) &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && tick));
  assign baud_clr = (state_reg == IDLE);

  assign bus.ready = ready;
  assign bus.busy  = (state_reg != IDLE) || (count_reg != '0);
  assign bus.tx    = tx_reg;

  baudgen_tx #(
    .BAUDRATE(BAUDRATE)
  ) u_baudgen (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  // Character storage carries no reset; occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= bus.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({wr_en, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // tx is registered and changes together with the state, so each bit
  // starts on the same edge as the transition that selects it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      tx_reg      <= 1'b1;
      shift_reg   <= '0;
      bit_idx_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= 1'b1;
          if (pop) begin
            shift_reg <= mem[rd_ptr_reg];
            tx_reg    <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (tick) begin
            tx_reg      <= shift_reg[0];
            shift_reg   <= {1'b0, shift_reg[DATA_W-1:1]};
            bit_idx_reg <= '0;
            state_reg   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= STOP;
            end else begin
              tx_reg      <= shift_reg[0];
              shift_reg   <= {1'b0, shift_reg[DATA_W-1:1]};
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (pop) begin
              shift_reg <= mem[rd_ptr_reg];
              tx_reg    <= 1'b0;
              state_reg <= START;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    count_reg <= COUNT_W'(FIFO_DEPTH));

  assert property (@(posedge clk) disable iff (rst)
    (state_reg == IDLE) |-> tx_reg);

endmodule

// File: tb/tb_uart_tx_buf.sv
// Scoreboard bench: a timing-level model predicts accepted characters and frame start edges.
module tb_uart_tx_buf;

  localparam int B  = 4;
  localparam int B2 = 104;

  typedef struct {
    int         wr;
    int         pop;
    logic [7:0] d;
  } ch_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buf_if bus4();
  uart_tx_buf_if bus104();

  uart_tx_buf #(.BAUDRATE(B))  dut4   (.clk(clk), .rst(rst), .bus(bus4));
  uart_tx_buf #(.BAUDRATE(B2)) dut104 (.clk(clk), .rst(rst), .bus(bus104));

  ch_t acc_q[$];
  ch_t exp_q[$];
  int  last_pop = -100000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Characters written and not yet started after edge k.
  function automatic int count_after(input int k);
    int c = 0;
    foreach (acc_q[i]) if (acc_q[i].wr <= k && acc_q[i].pop > k) c++;
    return c;
  endfunction

  // Busy from the write edge until the end of that character's stop bit.
  function automatic bit busy_after(input int k);
    foreach (acc_q[i]) if (acc_q[i].wr <= k && k < acc_q[i].pop + 10 * B) return 1'b1;
    return 1'b0;
  endfunction

  task automatic send(input logic [7:0] d, output bit acc, output int pop);
    int n;
    ch_t c;
    @(negedge clk);
    n   = cyc + 1;
    acc = (count_after(n - 1) < 4);
    check("ready_before_write", 32'(bus4.ready), 32'(acc));
    bus4.start = 1'b1;
    bus4.data  = d;
    pop = 0;
    if (acc) begin
      pop   = (n + 1 > last_pop + 10 * B) ? n + 1 : last_pop + 10 * B;
      c.wr  = n;
      c.pop = pop;
      c.d   = d;
      acc_q.push_back(c);
      exp_q.push_back(c);
      last_pop = pop;
    end
    $display("write %02h at edge %0d: %s", d, n, acc ? "accepted" : "dropped");
  endtask

  task automatic idle();
    @(negedge clk);
    bus4.start = 1'b0;
    bus4.data  = 8'($urandom);
  endtask

  task automatic drain();
    int t;
    t = last_pop + 10 * B + 2;
    while (cyc < t) idle();
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  // Per-cycle handshake check against the model.
  always @(negedge clk) begin
    check("ready", 32'(bus4.ready), 32'(count_after(cyc) < 4));
    check("busy", 32'(bus4.busy), 32'(busy_after(cyc)));
  end

  // Serial receiver / scoreboard: mid-bit sampling, compares with queue head.
  bit         mon_on = 1'b0;
  int         mon_start;
  logic [7:0] mon_byte;
  logic       mon_sb;

  always @(negedge clk) begin
    int  off;
    ch_t e;
    if (rst) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (bus4.tx == 1'b0) begin
        mon_on    = 1'b1;
        mon_start = cyc;
        mon_byte  = 8'h00;
        mon_sb    = 1'b0;
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      end
    end else begin
      off = cyc - mon_start;
      if (off == B / 2) begin
        mon_sb = (bus4.tx == 1'b0);
      end else if (off > B / 2 && off < B / 2 + 9 * B && ((off - B / 2) % B) == 0) begin
        mon_byte = {bus4.tx, mon_byte[7:1]};
      end else if (off == B / 2 + 9 * B) begin
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("frame_byte", 32'(mon_byte), 32'(e.d));
          check("frame_start_edge", 32'(mon_start), 32'(e.pop));
          check("frame_start_bit", 32'(mon_sb), 32'd1);
          check("frame_stop_bit", 32'(bus4.tx), 32'd1);
        end
        $display("frame %02h decoded, start edge %0d", mon_byte, mon_start);
        mon_on = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL global_timeout: run still active at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bit         acc;
    int         p;
    int         p_a5;
    int         t;
    int         n;
    int         s;
    int         e;
    logic [7:0] rx;
    logic       stopb;

    bus4.start   = 1'b0;
    bus4.data    = 8'h00;
    bus104.start = 1'b0;
    bus104.data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(bus4.tx), 32'd1);
    check("reset_ready", 32'(bus4.ready), 32'd1);
    check("reset_busy", 32'(bus4.busy), 32'd0);
    rst = 1'b0;
    $display("reset released at cycle %0d", cyc);
    idle();

    send(8'h55, acc, p);
    idle();
    drain();

    send(8'h4B, acc, p);
    send(8'h4F, acc, p);
    idle();
    drain();

    for (int i = 1; i <= 6; i++) send(8'(i), acc, p);
    idle();
    drain();

    // Full FIFO, write offered on the very edge the STOP-end pop happens.
    send(8'h11, acc, p);
    send(8'h22, acc, t);
    send(8'h33, acc, p);
    send(8'h44, acc, p);
    send(8'h66, acc, p);
    idle();
    while (cyc < t - 2) idle();
    send(8'hEE, acc, p);
    idle();
    check("ready_after_stop_pop", 32'(bus4.ready), 32'd1);
    drain();

    // Reset during bit3 of A5 with two characters waiting.
    send(8'hA5, acc, p_a5);
    send(8'h3C, acc, p);
    send(8'hC3, acc, p);
    idle();
    while (cyc < p_a5 + 4 * B + 1) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    acc_q.delete();
    exp_q.delete();
    last_pop = -100000;
    #1;
    check("midframe_rst_tx", 32'(bus4.tx), 32'd1);
    check("midframe_rst_busy", 32'(bus4.busy), 32'd0);
    check("midframe_rst_ready", 32'(bus4.ready), 32'd1);
    $display("reset asserted mid-frame at cycle %0d", cyc);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("reset released at cycle %0d", cyc);
    repeat (80) idle();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 99) < 45) send(8'($urandom), acc, p);
      else idle();
    end
    idle();
    drain();

    // Full-rate divisor: mid-bit sampling receiver on the second instance.
    @(negedge clk);
    n = cyc + 1;
    bus104.data  = 8'h55;
    bus104.start = 1'b1;
    @(negedge clk);
    bus104.start = 1'b0;
    $display("write 55 at edge %0d (BAUDRATE=%0d)", n, B2);
    s = -1;
    for (int i = 0; i < 20 && s < 0; i++) begin
      if (bus104.tx == 1'b0) s = cyc;
      else @(negedge clk);
    end
    check("b104_latency", 32'(s), 32'(n + 1));
    rx = 8'h00;
    stopb = 1'b0;
    for (int j = 1; j <= 9; j++) begin
      while (cyc < s + B2 / 2 + j * B2) @(negedge clk);
      if (j <= 8) rx = {bus104.tx, rx[7:1]};
      else stopb = bus104.tx;
    end
    check("b104_byte", 32'(rx), 32'h55);
    check("b104_stop_bit", 32'(stopb), 32'd1);
    e = -1;
    for (int i = 0; i < 200 && e < 0; i++) begin
      if (bus104.busy == 1'b0) e = cyc;
      else @(negedge clk);
    end
    check("b104_frame_len", 32'(e - s), 32'd1040);
    $display("frame %02h decoded at BAUDRATE=%0d, length %0d", rx, B2, e - s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buf.md
UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter BAUDRATE, default 104 (`B115200 at 12 MHz), clock cycles per serial bit.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port data  input  8  character to send.
REQ-005 SHALL have port start  input  1  write strobe; data is accepted on a rising edge when start=1 and ready=1.
REQ-006 SHALL have port ready  output  1  high when the FIFO has a free slot.
REQ-007 SHALL have port busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-008 SHALL have port tx  output  1  serial line, idle high; registered output, no combinational path from inputs.

Function
REQ-009 SHALL buffer characters in a 4-entry FIFO with 2-bit read/write pointers and a 3-bit count; pointers wrap 3->0.
REQ-010 SHALL drive ready = (count != 4), independent of a same-cycle pop.
REQ-011 SHALL ignore start while ready=0: no write, no pointer change, no overflow.
REQ-012 SHALL, on a simultaneous write and pop, leave count unchanged and advance both pointers.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1; if count>0, pop the head into an 8-bit shift register, set tx=0, go to START.
REQ-015 START: hold tx=0 for exactly BAUDRATE cycles, then set tx=data bit0 and go to DATA.
REQ-016 DATA: shift LSB first; each bit holds exactly BAUDRATE cycles; after bit7 set tx=1 and go to STOP.
REQ-017 STOP: hold tx=1 for BAUDRATE cycles; then, if count>0, pop and go directly to START (tx=0), else go to IDLE.
REQ-018 SHALL time each bit with a bit-period counter that reloads at every state/bit transition; no drift between consecutive bits or frames.
REQ-019 SHALL produce back-to-back frames of exactly 10*BAUDRATE cycles with no idle gap while the FIFO is non-empty.
REQ-020 Latency: with the FSM in IDLE and the FIFO empty, a write at edge N SHALL produce tx=0 starting at edge N+1.
REQ-021 SHALL keep an in-flight character unaffected by later writes; the shift register changes only on pop and bit shifts.
REQ-022 SHALL deassert busy on the same edge that the FSM returns to IDLE with count=0.

Reset
REQ-023 On rst=1 the block SHALL asynchronously force tx=1, FSM=IDLE, pointers=0, count=0, bit counters=0.
REQ-024 While rst=1 it SHALL drive ready=1 and busy=0.
REQ-025 Reset mid-frame SHALL abort the frame immediately: tx=1, all buffered characters discarded, no partial frame resumed after release.
REQ-026 FIFO storage contents SHALL need no reset.

Structure
REQ-027 Baud divisor constants (`B115200, `B57600, `B38400, `B19200, `B9600, `B4800, `B2400, `B1200, `B600, `B300) SHALL come from the shared baudgen.vh header; none redefined locally.
REQ-028 The bit-period counter SHALL be one sub-module, baudgen_tx (inputs clk, rst, clr; output 1-cycle tick every BAUDRATE cycles).
REQ-029 FIFO and FSM SHALL be inline in uart_tx_buf.

Verification (BAUDRATE=4 for speed, plus one run at 104)
REQ-030 Reset, then write 8'h55 -> tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, stop 4 cycles high; busy falls 40 cycles after tx falls.
REQ-031 Write "K" (8'h4B) and "O" (8'h4F) on consecutive cycles -> two contiguous 40-cycle frames, no idle gap; receiver model decodes 4B then 4F.
REQ-032 Write 6 characters 8'h01..8'h06 on consecutive cycles while the first is in flight -> ready low after the 5th write; the 6th write is dropped; 8'h01..8'h05 are transmitted.
REQ-033 Assert rst during bit3 of 8'hA5 with 2 characters queued -> tx=1 within the same cycle, busy=0, ready=1, and no further start bit after release.
REQ-034 With count=4 and STOP ending, pulse start the cycle the pop occurs -> write ignored (ready was 0), count becomes 3.
REQ-035 At BAUDRATE=104, the echo of 8'h55 checked by a sampling receiver at mid-bit -> byte 8'h55, frame length 1040 cycles.
